// File: rtl/vsc_pkg.sv
// Shared types and helpers for the vector stream checker.
// Holds the run-state encoding and the table address width derivation.
package vsc_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int vsc_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/vsc_table.sv
// Vector table: one {stimulus, expected} entry per word.
// Synchronous write, asynchronous read; contents survive reset.
module vsc_table
    import vsc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 3,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port; no reset so the table persists across runs.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vector_stream_checker.sv
// Plays a stored vector table into a combinational DUT and checks replies.
// One vector per APPLY/WAIT/CHECK period; reports errors and first failure.
module vector_stream_checker
    import vsc_pkg::*;
#(
    parameter int IN_W   = 2,
    parameter int OUT_W  = 1,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 4,
    localparam int AW    = vsc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [IN_W-1:0]  load_stim,
    input  logic [OUT_W-1:0] load_exp,
    input  logic [AW:0]      num_vec,
    input  logic             start,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [AW:0]      err_cnt,
    output logic [AW-1:0]    fail_idx,
    output logic [AW-1:0]    vec_idx
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TW = IN_W + OUT_W;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     last;
    logic [AW-1:0]     last_nxt;
    logic [AW:0]       n_clamp;
    logic [TW-1:0]     rdata;
    logic [IN_W-1:0]   tbl_stim;
    logic [OUT_W-1:0]  tbl_exp;
    logic              is_last;
    logic              miss;

    vsc_table #(
        .DEPTH (DEPTH),
        .W     (TW),
        .AW    (AW)
    ) u_table (
        .clk   (clk),
        .we    (load_en && !busy),
        .waddr (load_addr),
        .wdata ({load_stim, load_exp}),
        .raddr (vec_idx),
        .rdata (rdata)
    );

    assign tbl_stim = rdata[OUT_W +: IN_W];
    assign tbl_exp  = rdata[OUT_W-1:0];

    assign n_clamp  = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
    assign last_nxt = AW'(n_clamp - 1'b1);
    assign is_last  = (vec_idx == last);
    assign miss     = (dut_out != tbl_exp);

    assign busy     = (state == S_APPLY) || (state == S_WAIT) || (state == S_CHECK);
    assign done     = (state == S_DONE);
    assign pass     = done && (err_cnt == '0);
    assign mismatch = (state == S_CHECK) && miss;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: an empty run goes straight to DONE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (num_vec == '0) ? S_DONE : S_APPLY;
                end
            end
            S_APPLY: state_nxt = S_WAIT;
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: state_nxt = is_last ? S_DONE : S_APPLY;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: stimulus, settle counter, index and error bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in   <= '0;
            cnt      <= '0;
            last     <= '0;
            vec_idx  <= '0;
            err_cnt  <= '0;
            fail_idx <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        last     <= last_nxt;
                        vec_idx  <= '0;
                        err_cnt  <= '0;
                        fail_idx <= '0;
                    end
                end
                S_APPLY: begin
                    dut_in <= tbl_stim;
                    cnt    <= CW'(SETTLE - 1);
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CHECK: begin
                    if (miss) begin
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        if (err_cnt == '0) begin
                            fail_idx <= vec_idx;
                        end
                    end
                    if (!is_last) begin
                        vec_idx <= vec_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
